irst_ctrl: RTL
==============

// Module: irst_ctrl
// PURPOSE
//  In-run self test (IRST) controller beside the register file. Arms when R0 holds a command word with bit 15 set.
//  It stalls the pipeline, then writes per-pass patterns to R1..R7 and reads each back to compare.
//  It reports pass or fail, then pulses irst_done so the register file clears R0.
//  When irst_busy=1, the top level muxes irst_wr_*/irst_rd_addr over the writeback write port and decode read port 1.
// PARAMETERS
//  DATA_W        16  register width
//  ADDR_W        3   register address width (R0..R7)
//  DRAIN_CYCLES  4   stall cycles before the first IRST write, so the pipeline empties; must be >=1
// PORTS
//  clk            in   1       clock; everything is on the rising edge
//  rst            in   1       reset: synchronous, active-high
//  irst_reg_data  in   DATA_W  R0 contents: [15]=start, [11:8]=pass count N (0 means 1), [3:0]=seed; [14:12],[7:4] ignored
//  irst_done      out  1       one-cycle pulse at end of test; the register file clears R0 on that edge
//  irst_busy      out  1       high from DRAIN through DONE inclusive; selects the IRST muxes
//  pipe_stall     out  1       equals irst_busy; freezes the PC and IF/ID
//  irst_wr_en     out  1       register-file write enable
//  irst_wr_dest   out  ADDR_W  write address
//  irst_wr_data   out  DATA_W  write data
//  irst_rd_addr   out  ADDR_W  read address (register-file read is asynchronous)
//  irst_rd_data   in   DATA_W  read data for irst_rd_addr, valid in the same cycle
//  irst_pass      out  1       sticky: last test completed with no mismatch
//  irst_fail      out  1       sticky: last test hit a mismatch
//  irst_fail_reg  out  ADDR_W  register that mismatched (0 when none)
// BEHAVIOUR
//  All outputs are registered. On reset every output is 0 and state=IDLE.
//  Reset mid-test: abort, go to IDLE, clear all outputs. No irst_done pulse.
//  FSM states: IDLE, DRAIN, WRITE, READ, DONE.
//   IDLE : if irst_reg_data[15]=1, latch N and seed, clear pass/fail/fail_reg, go to DRAIN.
//   DRAIN: count DRAIN_CYCLES cycles, then WRITE with r=1, p=0.
//   WRITE: irst_wr_en=1, dest=r, data=pat(p,r); r increments each cycle. After r=7, go to READ with r=1.
//   READ : rd_addr=r. If rd_data != pat(p,r): fail=1, fail_reg=r, go to DONE immediately.
//          Otherwise r increments. After r=7: if p=N-1, pass=1 and go to DONE; else p+1 and go to WRITE with r=1.
//   DONE : irst_done=1 and busy=1 for exactly one cycle, then IDLE.
//  Pattern: base={4{seed}}; pat(p,r)=rotl16(base, p mod 16) ^ {13'b0,r}.
//   p is 4 bits wide. R0 is never written or read.
//  Timing: the cycle IDLE sees start is t. DRAIN covers t+1..t+DRAIN_CYCLES.
//   Each pass is 14 cycles (7 WRITE + 7 READ). DONE falls at t+DRAIN_CYCLES+14*N+1 on a clean run.
//  Re-trigger: R0 clears at the end of DONE, so IDLE sees start=0 next cycle; no re-arm.
//   A software write to R0 during busy is not sampled until IDLE.
//  pass/fail hold until the next start is accepted or rst. pass and fail are never both 1.
// STRUCTURE
//  mips_16_defs.v: FSM state encodings; command-field positions IRST_START_BIT=15, IRST_PASS_HI/LO=11/8, IRST_SEED_HI/LO=3/0.
//  Sub-module irst_pattern_gen: combinational pat(p,r) from seed, pass index and register index.
//   Instantiated once, shared by the WRITE and READ comparisons.
// TESTING
//  1 Reset, R0=16'h8F0F (N=15, seed=F). Require busy at cycle 1; first write R1=16'hFFFE, R7=16'hFFF8;
//    with DRAIN=4, irst_done at cycle 215; pass=1, fail=0.
//  2 R0=16'h8105 (N=1, seed=5). Require writes R1..R7 = 16'h5554..16'h5552; done at cycle 19; pass=1.
//  3 As test 2, but force rd_data for R4 to 16'h0000 in READ. Require fail=1, fail_reg=4, done pulse in the next cycle,
//    no further reads, pass=0.
//  4 R0=16'h0F0F (start=0). Run 100 cycles. Require busy=0, no writes, done never pulses.
//  5 Assert rst during pass 3 WRITE. Require all outputs 0 the next cycle, state=IDLE, no done pulse;
//    restart from R0 re-arm with identical timing to test 1.
//  6 R0=16'h8001 (N=0 means 1 pass). Require exactly 7 writes, then 7 reads, and R0 not rearmed after done.

Source files
------------

// File: rtl/irst_ctrl_pkg.sv
// Shared widths, command-word field positions and FSM encoding for the in-run self test controller.
package irst_ctrl_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 3;
    localparam int unsigned PASS_W = 4;
    localparam int unsigned SEED_W = 4;

    localparam int unsigned IRST_START_BIT = 15;
    localparam int unsigned IRST_PASS_HI   = 11;
    localparam int unsigned IRST_PASS_LO   = 8;
    localparam int unsigned IRST_SEED_HI   = 3;
    localparam int unsigned IRST_SEED_LO   = 0;

    localparam logic [ADDR_W-1:0] REG_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] REG_LAST  = ADDR_W'(7);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_DONE  = 3'd4
    } irst_state_e;

endpackage

// File: rtl/irst_ctrl_if.sv
// Register-file side bus of the self test controller: command word, write port and read port 1.
interface irst_ctrl_if;
    import irst_ctrl_pkg::*;

    logic [DATA_W-1:0] irst_reg_data;
    logic              irst_wr_en;
    logic [ADDR_W-1:0] irst_wr_dest;
    logic [DATA_W-1:0] irst_wr_data;
    logic [ADDR_W-1:0] irst_rd_addr;
    logic [DATA_W-1:0] irst_rd_data;

    modport master (
        input  irst_reg_data,
        input  irst_rd_data,
        output irst_wr_en,
        output irst_wr_dest,
        output irst_wr_data,
        output irst_rd_addr
    );

    modport slave (
        output irst_reg_data,
        output irst_rd_data,
        input  irst_wr_en,
        input  irst_wr_dest,
        input  irst_wr_data,
        input  irst_rd_addr
    );

endinterface

// File: rtl/irst_ctrl_pattern_gen.sv
// Test pattern for one register in one pass: the seed nibble replicated, rotated left by the pass index,
// with the register index folded into the low bits so every register holds a distinct value.
module irst_ctrl_pattern_gen
    import irst_ctrl_pkg::*;
(
    input  logic [SEED_W-1:0] seed,
    input  logic [PASS_W-1:0] pass_idx,
    input  logic [ADDR_W-1:0] reg_idx,
    output logic [DATA_W-1:0] pat_c
);

    logic [DATA_W-1:0]   base;
    logic [2*DATA_W-1:0] dbl;

    always_comb begin
        base  = {4{seed}};
        dbl   = {base, base} << pass_idx;
        pat_c = dbl[2*DATA_W-1:DATA_W] ^ DATA_W'(reg_idx);
    end

endmodule

// File: rtl/irst_ctrl.sv
// In-run self test controller: stalls the pipeline, writes per-pass patterns to R1..R7,
// reads them back and reports a sticky pass/fail result.
module irst_ctrl
    import irst_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    irst_ctrl_if.master       bus,
    output logic              irst_done,
    output logic              irst_busy,
    output logic              pipe_stall,
    output logic              irst_pass,
    output logic              irst_fail,
    output logic [ADDR_W-1:0] irst_fail_reg
);

    localparam int unsigned       DRAIN_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    irst_state_e        state_q, state_d;
    logic [ADDR_W-1:0]  r_q, r_d;
    logic [PASS_W-1:0]  p_q, p_d;
    logic [PASS_W-1:0]  plast_q, plast_d;
    logic [SEED_W-1:0]  seed_q, seed_d;
    logic [DRAIN_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]  pat_q, pat_nxt_c;
    logic               busy_d, done_d, pass_d, fail_d;
    logic [ADDR_W-1:0]  fail_reg_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_dest_q, wr_dest_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;
    logic [ADDR_W-1:0]  rd_addr_q, rd_addr_d;
    logic [PASS_W-1:0]  pass_cnt;
    logic               unused_cmd_bits;

    assign pass_cnt        = bus.irst_reg_data[IRST_PASS_HI:IRST_PASS_LO];
    assign unused_cmd_bits = ^{bus.irst_reg_data[14:12], bus.irst_reg_data[7:4]};

    // Driven with next-cycle indices so the write data can be registered; pat_q then
    // holds the pattern of the register currently being read back.
    irst_ctrl_pattern_gen u_pattern_gen (
        .seed     (seed_d),
        .pass_idx (p_d),
        .reg_idx  (r_d),
        .pat_c    (pat_nxt_c)
    );

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        p_d        = p_q;
        plast_d    = plast_q;
        seed_d     = seed_q;
        cnt_d      = cnt_q;
        pass_d     = irst_pass;
        fail_d     = irst_fail;
        fail_reg_d = irst_fail_reg;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        wr_en_d    = 1'b0;
        wr_dest_d  = '0;
        rd_addr_d  = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.irst_reg_data[IRST_START_BIT]) begin
                    seed_d     = bus.irst_reg_data[IRST_SEED_HI:IRST_SEED_LO];
                    plast_d    = (pass_cnt == '0) ? '0 : pass_cnt - PASS_W'(1);
                    pass_d     = 1'b0;
                    fail_d     = 1'b0;
                    fail_reg_d = '0;
                    cnt_d      = '0;
                    busy_d     = 1'b1;
                    state_d    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy_d = 1'b1;
                if (cnt_q == DRAIN_LAST) begin
                    r_d       = REG_FIRST;
                    p_d       = '0;
                    wr_en_d   = 1'b1;
                    wr_dest_d = REG_FIRST;
                    state_d   = ST_WRITE;
                end else begin
                    cnt_d = cnt_q + DRAIN_W'(1);
                end
            end
            ST_WRITE: begin
                busy_d = 1'b1;
                if (r_q == REG_LAST) begin
                    r_d       = REG_FIRST;
                    rd_addr_d = REG_FIRST;
                    state_d   = ST_READ;
                end else begin
                    r_d       = r_q + ADDR_W'(1);
                    wr_en_d   = 1'b1;
                    wr_dest_d = r_q + ADDR_W'(1);
                end
            end
            ST_READ: begin
                busy_d = 1'b1;
                if (bus.irst_rd_data != pat_q) begin
                    fail_d     = 1'b1;
                    fail_reg_d = r_q;
                    done_d     = 1'b1;
                    state_d    = ST_DONE;
                end else if (r_q != REG_LAST) begin
                    r_d       = r_q + ADDR_W'(1);
                    rd_addr_d = r_q + ADDR_W'(1);
                end else if (p_q == plast_q) begin
                    pass_d  = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    p_d       = p_q + PASS_W'(1);
                    r_d       = REG_FIRST;
                    wr_en_d   = 1'b1;
                    wr_dest_d = REG_FIRST;
                    state_d   = ST_WRITE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        wr_data_d = wr_en_d ? pat_nxt_c : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            r_q           <= '0;
            p_q           <= '0;
            plast_q       <= '0;
            seed_q        <= '0;
            cnt_q         <= '0;
            pat_q         <= '0;
            irst_busy     <= 1'b0;
            pipe_stall    <= 1'b0;
            irst_done     <= 1'b0;
            irst_pass     <= 1'b0;
            irst_fail     <= 1'b0;
            irst_fail_reg <= '0;
            wr_en_q       <= 1'b0;
            wr_dest_q     <= '0;
            wr_data_q     <= '0;
            rd_addr_q     <= '0;
        end else begin
            state_q       <= state_d;
            r_q           <= r_d;
            p_q           <= p_d;
            plast_q       <= plast_d;
            seed_q        <= seed_d;
            cnt_q         <= cnt_d;
            pat_q         <= pat_nxt_c;
            irst_busy     <= busy_d;
            pipe_stall    <= busy_d;
            irst_done     <= done_d;
            irst_pass     <= pass_d;
            irst_fail     <= fail_d;
            irst_fail_reg <= fail_reg_d;
            wr_en_q       <= wr_en_d;
            wr_dest_q     <= wr_dest_d;
            wr_data_q     <= wr_data_d;
            rd_addr_q     <= rd_addr_d;
        end
    end

    assign bus.irst_wr_en   = wr_en_q;
    assign bus.irst_wr_dest = wr_dest_q;
    assign bus.irst_wr_data = wr_data_q;
    assign bus.irst_rd_addr = rd_addr_q;

endmodule
